// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code source and the Gray-to-binary converter.
// The encoder works at a fixed maximum width; callers zero-extend in and truncate out.
package gray_pkg;

  localparam int GRAY_DATA_WIDTH = 16;
  localparam int GRAY_MAX_W      = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Zero-extension is harmless: the top Gray bit becomes b[msb] ^ 0 = b[msb].
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_gen_if.sv
// Output stream of the Gray-code source.
// A word transfers on a rising edge where out_valid and out_ready are both high; once
// out_valid rises, out_valid and out_gray hold unchanged until that transfer happens.
interface gray_seq_gen_if #(
  parameter int DATA_WIDTH = gray_pkg::GRAY_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] out_gray;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_gray, output out_valid, input out_ready);
  modport slave  (input out_gray, input out_valid, output out_ready);
endinterface

// File: rtl/gray_seq_gen.sv
// Emits a run of consecutive Gray codes (up or down, modulo 2^DATA_WIDTH) from a
// binary start value over a valid/ready stream. All outputs are registered.
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = GRAY_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] start_value,
  input  logic [DATA_WIDTH-1:0] length,
  gray_seq_gen_if.master        stream,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  state_t                state;
  logic [DATA_WIDTH-1:0] bin;
  logic [DATA_WIDTH-1:0] remaining;
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] next_bin;
  logic [DATA_WIDTH-1:0] start_gray;
  logic [DATA_WIDTH-1:0] next_gray;
  logic                  handshake;

  assign dbg_state = state;
  assign handshake = stream.out_valid && stream.out_ready;

  always_comb begin
    next_bin   = dir_q ? (bin - DATA_WIDTH'(1)) : (bin + DATA_WIDTH'(1));
    start_gray = DATA_WIDTH'(bin2gray(GRAY_MAX_W'(start_value)));
    next_gray  = DATA_WIDTH'(bin2gray(GRAY_MAX_W'(next_bin)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bin              <= '0;
      remaining        <= '0;
      dir_q            <= 1'b0;
      stream.out_gray  <= '0;
      stream.out_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length request is dropped without any visible effect.
          if (start && (length != '0)) begin
            state            <= RUN;
            bin              <= start_value;
            remaining        <= length;
            dir_q            <= dir;
            stream.out_gray  <= start_gray;
            stream.out_valid <= 1'b1;
            busy             <= 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            if (remaining == DATA_WIDTH'(1)) begin
              // out_gray keeps the last word; only valid/busy drop.
              state            <= IDLE;
              stream.out_valid <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
            end else begin
              remaining       <= remaining - DATA_WIDTH'(1);
              bin             <= next_bin;
              stream.out_gray <= next_gray;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
